paddle_ctrl: RTL and testbench

//  Player paddle controller for the pong game: the producer side of the p_y bus the ball block consumes.

---
 rtl/paddle_ctrl.sv | 152 +++++++++++++++
 tb/tb_paddle_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: synchronised, debounced two-speed paddle mover producing p_y for the ball and pixel blocks.
// Define PADDLE_AI_EN to add ball_y/auto_mode so the paddle can track the ball without the buttons.
module paddle_ctrl #(
    parameter int TICK_COUNT  = 500000,
    parameter int DB_TICKS    = 4,
    parameter int ACCEL_TICKS = 32,
    parameter int HEIGHT_P    = 72,
    parameter int BOTTOM_W    = 479,
    parameter int RESET_Y     = 204
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       recenter,
`ifdef PADDLE_AI_EN
    input  logic [9:0] ball_y,
    input  logic       auto_mode,
`endif
    output logic [9:0] p_y,
    output logic       moving
);
    localparam int TW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam int DW = $clog2(DB_TICKS + 1);
    localparam int SW = $clog2(ACCEL_TICKS + 1);
    localparam int NB = 2;
    localparam logic signed [10:0] MAX_S = 11'(BOTTOM_W - HEIGHT_P);

    typedef enum logic [2:0] {IDLE, SLOW_UP, FAST_UP, SLOW_DN, FAST_DN} state_t;

    logic [TW-1:0] tick_cnt;
    logic          tick;
    assign tick = (tick_cnt == TW'(TICK_COUNT - 1));

    always_ff @(posedge clk or negedge reset)
        if (!reset)    tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + TW'(1);

    // lane 0 = up, lane 1 = down; the raw pins reach nothing but the first sync flop
    logic [NB-1:0] btn_raw, db_level;
    assign btn_raw = {btn_down, btn_up};

    genvar g;
    generate
        for (g = 0; g < NB; g++) begin : g_btn
            logic [1:0]    sync;
            logic [DW-1:0] db_cnt;
            logic          lvl;
            always_ff @(posedge clk or negedge reset)
                if (!reset) begin
                    sync   <= '0;
                    db_cnt <= '0;
                    lvl    <= 1'b0;
                end else begin
                    sync <= {sync[0], btn_raw[g]};
                    if (tick) begin
                        if (sync[1] != lvl) begin
                            if (db_cnt == DW'(DB_TICKS - 1)) begin
                                lvl    <= ~lvl;
                                db_cnt <= '0;
                            end else
                                db_cnt <= db_cnt + DW'(1);
                        end else
                            db_cnt <= '0;
                    end
                end
            assign db_level[g] = lvl;
        end
    endgenerate

    logic want_up, want_dn;
`ifdef PADDLE_AI_EN
    logic [11:0] ball_c, pad_c;
    assign ball_c = {2'b00, ball_y} + 12'd4;
    assign pad_c  = {2'b00, p_y} + 12'(HEIGHT_P / 2);
    always_comb begin
        want_up = db_level[0] & ~db_level[1];
        want_dn = db_level[1] & ~db_level[0];
        if (auto_mode) begin
            want_up = (ball_c + 12'd4) < pad_c;
            want_dn = ball_c > (pad_c + 12'd4);
        end
    end
`else
    assign want_up = db_level[0] & ~db_level[1];
    assign want_dn = db_level[1] & ~db_level[0];
`endif

    state_t        state, state_nx;
    logic [SW-1:0] step, step_nx;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= IDLE;
            step  <= '0;
        end else if (recenter) begin
            state <= IDLE;
            step  <= '0;
        end else if (tick) begin
            state <= state_nx;
            step  <= step_nx;
        end

    // SLOW_x means the next step in x is 1 px; entering a direction counts as the first slow step
    always_comb begin
        state_nx = IDLE;
        step_nx  = '0;
        if (want_up) begin
            if (state == FAST_UP) begin
                state_nx = FAST_UP;
                step_nx  = step;
            end else begin
                step_nx  = (state == SLOW_UP) ? step + SW'(1) : SW'(1);
                state_nx = (step_nx >= SW'(ACCEL_TICKS)) ? FAST_UP : SLOW_UP;
            end
        end else if (want_dn) begin
            if (state == FAST_DN) begin
                state_nx = FAST_DN;
                step_nx  = step;
            end else begin
                step_nx  = (state == SLOW_DN) ? step + SW'(1) : SW'(1);
                state_nx = (step_nx >= SW'(ACCEL_TICKS)) ? FAST_DN : SLOW_DN;
            end
        end
    end

    logic signed [10:0] delta, py_sum;
    logic [9:0]         py_nx;

    always_comb begin
        delta = '0;
        if (want_up)      delta = (state == FAST_UP) ? -11'sd2 : -11'sd1;
        else if (want_dn) delta = (state == FAST_DN) ?  11'sd2 :  11'sd1;
        py_sum = $signed({1'b0, p_y}) + delta;
        if (py_sum < 0)          py_nx = '0;
        else if (py_sum > MAX_S) py_nx = MAX_S[9:0];
        else                     py_nx = py_sum[9:0];
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            p_y    <= 10'(RESET_Y);
            moving <= 1'b0;
        end else if (recenter) begin
            p_y    <= 10'(RESET_Y);
            moving <= 1'b0;
        end else if (tick) begin
            p_y    <= py_nx;
            moving <= (py_nx != p_y);
        end
endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: a run-length behavioural model checked every cycle, plus literal anchors.
module tb_paddle_ctrl;
    localparam int TC = 4, DB = 2, AC = 3, MAXY = 407, RY = 204;

    logic clk = 1'b0, reset = 1'b0, btn_up = 1'b0, btn_down = 1'b0, recenter = 1'b0;
`ifdef PADDLE_AI_EN
    logic [9:0] ball_y = '0;
    logic       auto_mode = 1'b0;
`endif
    logic [9:0] p_y;
    logic       moving;

    paddle_ctrl #(.TICK_COUNT(TC), .DB_TICKS(DB), .ACCEL_TICKS(AC),
                  .HEIGHT_P(72), .BOTTOM_W(479), .RESET_Y(RY)) dut (
        .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .recenter(recenter),
`ifdef PADDLE_AI_EN
        .ball_y(ball_y), .auto_mode(auto_mode),
`endif
        .p_y(p_y), .moving(moving));

    always #5 clk = ~clk;

    int checks = 0, passed = 0;
    int m_tc, m_py, m_mv, m_run, m_last;
    int m_h1[2], m_h2[2], m_lvl[2], m_cnt[2];
    bit m_ticked;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        m_tc = 0; m_py = RY; m_mv = 0; m_run = 0; m_last = 0; m_ticked = 0;
        for (int b = 0; b < 2; b++) begin
            m_h1[b] = 0; m_h2[b] = 0; m_lvl[b] = 0; m_cnt[b] = 0;
        end
    endtask

    // One clock edge of the model: dir (-1 up, +1 down) from last accepted levels,
    // speed from how many consecutive ticks that direction has been requested.
    task automatic model_edge();
        int dir, np;
        int ins[2];
        ins[0] = int'(btn_up);
        ins[1] = int'(btn_down);
        m_ticked = (m_tc == TC - 1);
        dir = (m_lvl[0] == 1 && m_lvl[1] == 0) ? -1 : (m_lvl[1] == 1 && m_lvl[0] == 0) ? 1 : 0;
`ifdef PADDLE_AI_EN
        if (auto_mode) begin
            dir = (int'(ball_y) + 4 < m_py + 36 - 4) ? -1 : (int'(ball_y) + 4 > m_py + 36 + 4) ? 1 : 0;
        end
`endif
        if (recenter) begin
            m_py = RY; m_mv = 0; m_run = 0; m_last = 0;
        end else if (m_ticked) begin
            if (dir == 0) begin
                m_run = 0; m_mv = 0;
            end else begin
                m_run = (dir == m_last) ? m_run + 1 : 1;
                np = m_py + dir * ((m_run <= AC) ? 1 : 2);
                if (np < 0) np = 0;
                if (np > MAXY) np = MAXY;
                m_mv = (np != m_py) ? 1 : 0;
                m_py = np;
            end
            m_last = dir;
        end
        if (m_ticked) begin
            for (int b = 0; b < 2; b++) begin
                if (m_h2[b] != m_lvl[b]) begin
                    m_cnt[b]++;
                    if (m_cnt[b] == DB) begin m_lvl[b] = 1 - m_lvl[b]; m_cnt[b] = 0; end
                end else m_cnt[b] = 0;
            end
        end
        for (int b = 0; b < 2; b++) begin m_h2[b] = m_h1[b]; m_h1[b] = ins[b]; end
        m_tc = m_ticked ? 0 : m_tc + 1;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!reset) model_reset();
        else model_edge();
        @(negedge clk);
        check("p_y", int'(p_y), m_py);
        check("moving", int'(moving), m_mv);
    endtask

    int exp_py[5] = '{205, 206, 207, 209, 211};
    int k, prev;

    initial begin
        model_reset();
        repeat (3) cycle();
        check("rst_py", int'(p_y), RY);
        check("rst_moving", int'(moving), 0);
        reset = 1'b1;

        // 1: idle
        repeat (200) cycle();
        check("t1_py", int'(p_y), RY);

        // 2: down held from a tick-aligned start
        for (int i = 0; i < 8 && m_tc != 0; i++) cycle();
        btn_down = 1'b1;
        k = 0;
        for (int i = 0; i < 7 * TC; i++) begin
            cycle();
            if (m_ticked) begin
                k++;
                if (k <= 2) check("t2_hold", int'(p_y), RY);
                else begin
                    check("t2_py", int'(p_y), exp_py[k-3]);
                    check("t2_moving", int'(moving), 1);
                end
            end
        end

        // 3: clamp at the bottom, then reverse
        repeat (110 * TC) cycle();
        check("t3_clamp", int'(p_y), MAXY);
        check("t3_pinned", int'(moving), 0);
        btn_down = 1'b0;
        btn_up = 1'b1;
        for (int i = 0; i < 60 && p_y == 10'(MAXY); i++) cycle();
        check("t3_reverse", int'(p_y), 406);

        // async reset mid-movement
        repeat (5 * TC) cycle();
        #2 reset = 1'b0;
        #1;
        check("async_py", int'(p_y), RY);
        check("async_moving", int'(moving), 0);
        model_reset();
        btn_up = 1'b0;
        repeat (2) cycle();
        reset = 1'b1;

        // 4: one-tick glitch rejected, then both buttons
        btn_up = 1'b1;
        repeat (TC) cycle();
        btn_up = 1'b0;
        repeat (40) cycle();
        check("t4_glitch", int'(p_y), RY);
        btn_up = 1'b1;
        btn_down = 1'b1;
        repeat (60) cycle();
        check("t4_both", int'(p_y), RY);
        check("t4_both_mv", int'(moving), 0);

        // 5: recenter on a tick while moving fast up
        btn_down = 1'b0;
        for (int i = 0; i < 600 && !(m_py <= 101 && m_run > AC); i++) cycle();
        for (int i = 0; i < 8 && m_tc != TC - 1; i++) cycle();
        recenter = 1'b1;
        cycle();
        recenter = 1'b0;
        check("t5_recenter", int'(p_y), RY);
        check("t5_rc_moving", int'(moving), 0);
        m_ticked = 0;
        for (int i = 0; i < 8 && !m_ticked; i++) cycle();
        check("t5_slow", int'(p_y), RY - 1);
        check("t5_slow_mv", int'(moving), 1);
        repeat (110 * TC) cycle();
        check("t5_top", int'(p_y), 0);
        check("t5_top_mv", int'(moving), 0);
        btn_up = 1'b0;

`ifdef PADDLE_AI_EN
        // 6: ball tracking
        recenter = 1'b1;
        cycle();
        recenter = 1'b0;
        auto_mode = 1'b1;
        ball_y = 10'd100;
        prev = int'(p_y);
        k = 0;
        for (int i = 0; i < 40 && k < 5; i++) begin
            cycle();
            if (m_ticked) begin
                k++;
                check("t6_dec", int'(int'(p_y) < prev), 1);
                prev = int'(p_y);
            end
        end
        recenter = 1'b1;
        cycle();
        recenter = 1'b0;
        ball_y = 10'd236;
        repeat (40) cycle();
        check("t6_hold", int'(p_y), RY);
        auto_mode = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
